score_display_ctrl: RTL and testbench

- Sequencing/arbitration front end for the 4-digit multiplexed seven-segment driver.
- Converts the binary game score and the binary high score to packed BCD on one shared sequential double-dabble converter.
- Presents the selected 16-bit BCD word on `number`, which feeds the display driver directly.
- During game-over, alternates the displayed value between score and high score at a fixed period.

---
 rtl/score_display_ctrl_pkg.sv | 19 +
 rtl/score_display_ctrl_if.sv | 23 ++
 rtl/score_display_ctrl_bin2bcd_seq.sv | 78 +++++++
 rtl/score_display_ctrl.sv | 122 ++++++++++++
 tb/tb_score_display_ctrl.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/score_display_ctrl_pkg.sv
// Shared constants and encodings for the score display front end.
package score_display_ctrl_pkg;

  localparam int BCD_W    = 16;
  localparam int MAX_DISP = 9999;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } conv_state_t;

  typedef enum logic {
    SRC_SCORE = 1'b0,
    SRC_HI    = 1'b1
  } src_t;

endpackage

// File: rtl/score_display_ctrl_if.sv
// Request/display bundle between the game logic and the score display front end.
interface score_display_ctrl_if #(
  parameter int VAL_W = 14
);
  logic [VAL_W-1:0] score;
  logic             score_valid;
  logic [VAL_W-1:0] hi_score;
  logic             hi_valid;
  logic             game_over;
  logic [15:0]      number;
  logic             show_hi;
  logic             busy;

  modport master (
    output score, score_valid, hi_score, hi_valid, game_over,
    input  number, show_hi, busy
  );

  modport slave (
    input  score, score_valid, hi_score, hi_valid, game_over,
    output number, show_hi, busy
  );
endinterface

// File: rtl/score_display_ctrl_bin2bcd_seq.sv
// Sequential double-dabble binary to packed BCD converter, one bit per cycle.
//
// state | meaning
// IDLE  | waiting for start; busy low
// LOAD  | operand captured in the shift register, first iteration runs
// SHIFT | remaining iterations, one add-3/shift per cycle
// DONE  | result stable on bcd, done high for one cycle
module bin2bcd_seq
  import score_display_ctrl_pkg::*;
#(
  parameter int VAL_W = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [VAL_W-1:0] value,
  output logic             done,
  output logic             busy,
  output logic [BCD_W-1:0] bcd
);

  localparam int SH_W   = BCD_W + VAL_W;
  localparam int ITER_W = $clog2(VAL_W + 1);
  localparam int DIGITS = BCD_W / 4;

  conv_state_t       state;
  logic [SH_W-1:0]   sh;
  logic [ITER_W-1:0] iter;

  // One double-dabble iteration: correct every BCD nibble >= 5, then shift left.
  function automatic logic [SH_W-1:0] dabble(input logic [SH_W-1:0] s);
    logic [SH_W-1:0] r;
    r = s;
    for (int i = 0; i < DIGITS; i++) begin
      if (r[VAL_W+4*i +: 4] >= 4'd5)
        r[VAL_W+4*i +: 4] = r[VAL_W+4*i +: 4] + 4'd3;
    end
    return {r[SH_W-2:0], 1'b0};
  endfunction

  // Converter FSM and datapath; reset aborts any conversion in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sh    <= '0;
      iter  <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sh    <= {{BCD_W{1'b0}}, value};
            iter  <= '0;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD, SHIFT: begin
          sh   <= dabble(sh);
          iter <= iter + ITER_W'(1);
          if (iter == ITER_W'(VAL_W - 1))
            state <= DONE;
          else
            state <= SHIFT;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign done = (state == DONE);
  assign bcd  = sh[SH_W-1 -: BCD_W];

endmodule

// File: rtl/score_display_ctrl.sv
// Score display front end: request capture, converter arbitration,
// game-over score/high-score alternation and the registered display mux.
module score_display_ctrl
  import score_display_ctrl_pkg::*;
#(
  parameter int VAL_W      = 14,
  parameter int ALT_PERIOD = 200_000_000,
  parameter int CNT_W      = 28
) (
  input  logic clk,
  input  logic rst,
  score_display_ctrl_if.slave bus
);

  logic [VAL_W-1:0] score_hold;
  logic [VAL_W-1:0] hi_hold;
  logic [VAL_W-1:0] sel_hold;
  logic [VAL_W-1:0] conv_in;
  logic             pend_s;
  logic             pend_h;
  logic             conv_start;
  logic             conv_done;
  logic             conv_busy;
  src_t             pick;
  src_t             grant;
  logic [BCD_W-1:0] conv_bcd;
  logic [BCD_W-1:0] score_bcd;
  logic [BCD_W-1:0] hi_bcd;
  logic [BCD_W-1:0] number_q;
  logic [CNT_W-1:0] phase_cnt;
  logic             show_hi_q;

  // Fixed-priority pick (score first) and saturation of the operand to four digits.
  always_comb begin
    pick     = pend_s ? SRC_SCORE : SRC_HI;
    sel_hold = pend_s ? score_hold : hi_hold;
    conv_in  = (sel_hold > VAL_W'(MAX_DISP)) ? VAL_W'(MAX_DISP) : sel_hold;
  end

  assign conv_start = !conv_busy && (pend_s || pend_h);

  // Capture requests; a fresh pulse on the same edge as a grant re-arms the flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score_hold <= '0;
      hi_hold    <= '0;
      pend_s     <= 1'b0;
      pend_h     <= 1'b0;
      grant      <= SRC_SCORE;
    end else begin
      if (conv_start) begin
        grant <= pick;
        if (pick == SRC_SCORE)
          pend_s <= 1'b0;
        else
          pend_h <= 1'b0;
      end
      if (bus.score_valid) begin
        score_hold <= bus.score;
        pend_s     <= 1'b1;
      end
      if (bus.hi_valid) begin
        hi_hold <= bus.hi_score;
        pend_h  <= 1'b1;
      end
    end
  end

  bin2bcd_seq #(
    .VAL_W (VAL_W)
  ) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .value (conv_in),
    .done  (conv_done),
    .busy  (conv_busy),
    .bcd   (conv_bcd)
  );

  // Commit a finished conversion to the register of the granted source in one step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score_bcd <= '0;
      hi_bcd    <= '0;
    end else if (conv_done) begin
      if (grant == SRC_SCORE)
        score_bcd <= conv_bcd;
      else
        hi_bcd <= conv_bcd;
    end
  end

  // Game-over phase timer: toggles show_hi every ALT_PERIOD cycles, idle otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_cnt <= '0;
      show_hi_q <= 1'b0;
    end else if (!bus.game_over) begin
      phase_cnt <= '0;
      show_hi_q <= 1'b0;
    end else if (phase_cnt == CNT_W'(ALT_PERIOD - 1)) begin
      phase_cnt <= '0;
      show_hi_q <= ~show_hi_q;
    end else begin
      phase_cnt <= phase_cnt + CNT_W'(1);
    end
  end

  // Registered display mux feeding the digit driver.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      number_q <= '0;
    else
      number_q <= show_hi_q ? hi_bcd : score_bcd;
  end

  assign bus.number  = number_q;
  assign bus.show_hi = show_hi_q;
  assign bus.busy    = conv_busy;

endmodule

// File: tb/tb_score_display_ctrl.sv
// Directed bench for score_display_ctrl with a short alternation period.
module tb_score_display_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  logic seen_77;

  score_display_ctrl_if #(.VAL_W(14)) bus ();

  score_display_ctrl #(
    .VAL_W      (14),
    .ALT_PERIOD (10),
    .CNT_W      (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watch for a value that must never reach the display.
  always @(negedge clk) begin
    if (bus.number == 16'h0077)
      seen_77 = 1'b1;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Leaves the bench just after the request edge (edge 0).
  task automatic pulse(input logic s_v, input logic [13:0] s, input logic h_v, input logic [13:0] h);
    bus.score       = s;
    bus.score_valid = s_v;
    bus.hi_score    = h;
    bus.hi_valid    = h_v;
    step(1);
    bus.score_valid = 1'b0;
    bus.hi_valid    = 1'b0;
  endtask

  logic [13:0] sat_in  [4];
  logic [15:0] sat_exp [4];

  initial begin
    n_checks        = 0;
    n_errors        = 0;
    seen_77         = 1'b0;
    rst             = 1'b1;
    bus.score       = '0;
    bus.score_valid = 1'b0;
    bus.hi_score    = '0;
    bus.hi_valid    = 1'b0;
    bus.game_over   = 1'b0;
    sat_in  = '{14'd16383, 14'd10000, 14'd9999, 14'd0};
    sat_exp = '{16'h9999, 16'h9999, 16'h9999, 16'h0000};

    step(2);
    check("rst_number", bus.number, 16'h0000);
    check("rst_show_hi", 16'(bus.show_hi), 16'h0000);
    check("rst_busy", 16'(bus.busy), 16'h0000);
    rst = 1'b0;
    step(2);

    // Latency: request edge 0, busy from edge 1, number at edge 17.
    pulse(1'b1, 14'd1234, 1'b0, 14'd0);
    check("lat_busy_e0", 16'(bus.busy), 16'h0000);
    step(1);
    check("lat_busy_e1", 16'(bus.busy), 16'h0001);
    step(14);
    check("lat_busy_e15", 16'(bus.busy), 16'h0001);
    step(1);
    check("lat_number_e16", bus.number, 16'h0000);
    check("lat_busy_e16", 16'(bus.busy), 16'h0000);
    step(1);
    check("lat_number_e17", bus.number, 16'h1234);
    step(2);

    // Saturation and zero.
    for (int i = 0; i < 4; i++) begin
      pulse(1'b1, sat_in[i], 1'b0, 14'd0);
      step(17);
      check($sformatf("sat_%0d", sat_in[i]), bus.number, sat_exp[i]);
      step(2);
    end

    // Overwrite while busy: 5 converts, 77 is replaced by 88 before it is granted.
    pulse(1'b1, 14'd5, 1'b0, 14'd0);
    step(2);
    bus.score = 14'd77; bus.score_valid = 1'b1;
    step(1);
    bus.score_valid = 1'b0;
    step(2);
    bus.score = 14'd88; bus.score_valid = 1'b1;
    step(1);
    bus.score_valid = 1'b0;
    step(11);
    check("ovw_first_e17", bus.number, 16'h0005);
    step(15);
    check("ovw_hold_e32", bus.number, 16'h0005);
    step(1);
    check("ovw_last_e33", bus.number, 16'h0088);
    check("ovw_no_77", 16'(seen_77), 16'h0000);
    step(3);

    // Simultaneous requests: score first, high score back to back.
    pulse(1'b1, 14'd42, 1'b1, 14'd907);
    step(16);
    check("sim_busy_gap_e16", 16'(bus.busy), 16'h0000);
    step(1);
    check("sim_busy_hi_e17", 16'(bus.busy), 16'h0001);
    check("sim_score_e17", bus.number, 16'h0042);
    step(15);
    check("sim_busy_end_e32", 16'(bus.busy), 16'h0000);
    bus.game_over = 1'b1;
    step(10);
    check("sim_show_hi", 16'(bus.show_hi), 16'h0001);
    step(1);
    check("sim_hi_number", bus.number, 16'h0907);
    bus.game_over = 1'b0;
    step(1);
    check("sim_show_hi_off", 16'(bus.show_hi), 16'h0000);
    step(1);
    check("sim_score_back", bus.number, 16'h0042);

    // Alternation with a 10-cycle phase.
    pulse(1'b1, 14'd12, 1'b1, 14'd321);
    step(40);
    check("alt_pre", bus.number, 16'h0012);
    bus.game_over = 1'b1;
    step(9);
    check("alt_show_hi_early", 16'(bus.show_hi), 16'h0000);
    step(1);
    check("alt_show_hi_rise", 16'(bus.show_hi), 16'h0001);
    step(1);
    check("alt_number_hi", bus.number, 16'h0321);
    step(9);
    check("alt_show_hi_fall", 16'(bus.show_hi), 16'h0000);
    step(1);
    check("alt_number_score", bus.number, 16'h0012);
    step(9);
    check("alt_show_hi_rise2", 16'(bus.show_hi), 16'h0001);
    step(3);
    bus.game_over = 1'b0;
    step(1);
    check("alt_drop_show_hi", 16'(bus.show_hi), 16'h0000);
    step(1);
    check("alt_drop_number", bus.number, 16'h0012);

    // Reset in the middle of a conversion.
    pulse(1'b1, 14'd1234, 1'b0, 14'd0);
    step(4);
    check("rmid_busy_e4", 16'(bus.busy), 16'h0001);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rmid_number", bus.number, 16'h0000);
    check("rmid_busy", 16'(bus.busy), 16'h0000);
    step(2);
    rst = 1'b0;
    step(30);
    check("rmid_no_stale", bus.number, 16'h0000);
    check("rmid_busy_after", 16'(bus.busy), 16'h0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
